// File: rtl/sys_bus_uart_if.sv
// System-bus slave interface for sys_bus_uart: decoder select, read/write
// controls, address and data buses.
interface sys_bus_uart_if;
    logic        sel;
    logic [2:0]  bus_rd_ctrl;
    logic [2:0]  bus_wr_ctrl;
    logic [63:0] bus_addr;
    logic [63:0] bus_din;
    logic [63:0] bus_dout;

    modport master (
        output sel, bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din,
        input  bus_dout
    );

    modport slave (
        input  sel, bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din,
        output bus_dout
    );
endinterface

// File: rtl/sys_bus_uart.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divider, status/control
// registers and level TX-done interrupt. Define UART_PARITY_EN to add a parity bit.
module sys_bus_uart #(
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic           clk,
    input  logic           rst,
    sys_bus_uart_if.slave  bus,
    output logic           uart_tx,
    output logic           irq
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [15:0]        baud_q;
    logic [2:0]         ctrl_q;
    logic               ovf_q;
    logic               irq_q;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        per_q, per_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
`ifdef UART_PARITY_EN
    logic               par_q, par_d;
`endif

    logic        rd_en, wr_en, push, push_ok, pop, full, empty, busy, bit_end;
    logic [1:0]  idx;
    logic [7:0]  head;
    logic [15:0] per_eff;
    logic [63:0] status;
    logic        unused_bits;

    assign rd_en   = bus.sel && (bus.bus_rd_ctrl != 3'd0);
    assign wr_en   = bus.sel && (bus.bus_wr_ctrl != 3'd0);
    assign idx     = bus.bus_addr[3:2];
    assign push    = wr_en && (idx == 2'd0);
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign busy    = (state_q != S_IDLE);
    assign head    = mem_q[rd_ptr_q];
    assign per_eff = (baud_q == '0) ? 16'd1 : baud_q;
    assign bit_end = (cnt_q == per_q - 16'd1);
    assign irq     = irq_q;

    assign unused_bits = ^{bus.bus_addr[63:4], bus.bus_addr[1:0], bus.bus_din[63:16]};

    always_comb begin
        status = '0;
        status[0] = full;
        status[1] = empty;
        status[2] = busy;
        status[3] = ovf_q;
        status[8 +: FIFO_AW + 1] = count_q;
    end

    always_comb begin
        bus.bus_dout = '0;
        if (rd_en) begin
            case (idx)
                2'd1:    bus.bus_dout = status;
                2'd2:    bus.bus_dout = {48'd0, baud_q};
                2'd3:    bus.bus_dout = {61'd0, ctrl_q};
                default: bus.bus_dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.bus_din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= DIV_RESET;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped byte in the same cycle as a W1C keeps OVF set.
            if (push && !push_ok)
                ovf_q <= 1'b1;
            else if (wr_en && idx == 2'd1 && bus.bus_din[3])
                ovf_q <= 1'b0;
            if (wr_en && idx == 2'd2) baud_q <= bus.bus_din[15:0];
`ifdef UART_PARITY_EN
            if (wr_en && idx == 2'd3) ctrl_q <= bus.bus_din[2:0];
`else
            if (wr_en && idx == 2'd3) ctrl_q <= {1'b0, bus.bus_din[1:0]};
`endif
            irq_q <= ctrl_q[1] && empty && (state_q == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= 16'd1;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Each bit boundary restarts the baud counter and resamples the divider.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        per_d   = per_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;
        uart_tx = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ctrl_q[0] && !empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_PARITY_EN
                    par_d   = ^head;
`endif
                    per_d   = per_eff;
                    state_d = S_START;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    per_d   = per_eff;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                uart_tx = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    per_d   = per_eff;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                uart_tx = par_q ^ ctrl_q[2];
                if (bit_end) begin
                    cnt_d   = '0;
                    per_d   = per_eff;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                uart_tx = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    per_d   = per_eff;
                    if (ctrl_q[0] && !empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_PARITY_EN
                        par_d   = ^head;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_bus_uart.sv
// Self-checking bench for sys_bus_uart: register vector table plus directed
// frame sequences (8N1 timing, FIFO overflow, back-to-back, irq, reset).
module tb_sys_bus_uart;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx, irq;

    sys_bus_uart_if bus ();

    sys_bus_uart #(.FIFO_AW(4), .DIV_RESET(16'd868)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

`ifdef UART_PARITY_EN
    localparam int NSLOT = 11;
    localparam logic [63:0] CTRL_ALL = 64'h7;
`else
    localparam int NSLOT = 10;
    localparam logic [63:0] CTRL_ALL = 64'h3;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [1:0]  idx;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.sel = 1'b0;
        bus.bus_rd_ctrl = '0;
        bus.bus_wr_ctrl = '0;
        bus.bus_addr = '0;
        bus.bus_din = '0;
    endtask

    task automatic bus_write(input bit s, input logic [1:0] idx, input logic [63:0] d);
        bus.sel = s;
        bus.bus_rd_ctrl = '0;
        bus.bus_wr_ctrl = 3'd3;
        bus.bus_addr = 64'h100 | (64'(idx) << 2);
        bus.bus_din = d;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic set_read(input bit s, input logic [1:0] idx);
        bus.sel = s;
        bus.bus_wr_ctrl = '0;
        bus.bus_rd_ctrl = 3'd1;
        bus.bus_addr = 64'h100 | (64'(idx) << 2);
    endtask

    task automatic bus_read(input bit s, input logic [1:0] idx, output logic [63:0] d);
        @(negedge clk);
        set_read(s, idx);
        #1;
        d = bus.bus_dout;
        idle_bus();
    endtask

    task automatic capture(input int p, input int bound, output logic [7:0] data,
                           output int bad, output int busy_n, output int irq_n, output bit found);
        logic lvl;
        found = 1'b0; bad = 0; busy_n = 0; irq_n = 0; data = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        for (int s = 0; s < NSLOT; s++) begin
            for (int j = 0; j < p; j++) begin
                if (!(s == 0 && j == 0)) @(negedge clk);
                if (s >= 1 && s <= 8 && j == 0) data[s-1] = uart_tx;
                if (s == 0)                lvl = 1'b0;
                else if (s <= 8)           lvl = data[s-1];
                else if (s == NSLOT - 1)   lvl = 1'b1;
                else                       lvl = ^data;
                if (uart_tx !== lvl) bad++;
                if (bus.bus_dout[2]) busy_n++;
                if (irq) irq_n++;
            end
        end
    endtask

    task automatic frame_check(input string name, input logic [7:0] exp, input int p, input int bound);
        logic [7:0] data;
        int bad, busy_n, irq_n;
        bit found;
        capture(p, bound, data, bad, busy_n, irq_n, found);
        check({name, "_start"}, 64'(found), 64'd1);
        check({name, "_byte"}, 64'(data), 64'(exp));
        check({name, "_timing"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  data;
        int bad, busy_n, irq_n;
        bit found;

        vt.push_back('{1, 0, 2'd1, 64'h0,                  64'h2});
        vt.push_back('{1, 0, 2'd2, 64'h0,                  64'd868});
        vt.push_back('{1, 0, 2'd3, 64'h0,                  64'h0});
        vt.push_back('{1, 0, 2'd0, 64'h0,                  64'h0});
        vt.push_back('{0, 0, 2'd1, 64'h0,                  64'h0});
        vt.push_back('{1, 1, 2'd2, 64'hFFFF_FFFF_FFFF_1234, 64'h0});
        vt.push_back('{1, 0, 2'd2, 64'h0,                  64'h1234});
        vt.push_back('{0, 1, 2'd2, 64'h7,                  64'h0});
        vt.push_back('{1, 0, 2'd2, 64'h0,                  64'h1234});
        vt.push_back('{1, 1, 2'd3, 64'hFF,                 64'h0});
        vt.push_back('{1, 0, 2'd3, 64'h0,                  CTRL_ALL});
        vt.push_back('{1, 1, 2'd3, 64'h0,                  64'h0});
        vt.push_back('{1, 0, 2'd3, 64'h0,                  64'h0});
        vt.push_back('{1, 1, 2'd1, 64'hFFFF,               64'h0});
        vt.push_back('{1, 0, 2'd1, 64'h0,                  64'h2});
        vt.push_back('{1, 1, 2'd2, 64'h0,                  64'h0});
        vt.push_back('{1, 0, 2'd2, 64'h0,                  64'h0});

        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx", 64'(uart_tx), 64'd1);
        check("rst_irq", 64'(irq), 64'd0);

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                bus_write(vt[i].sel, vt[i].idx, vt[i].din);
            end else begin
                bus_read(vt[i].sel, vt[i].idx, d);
                check($sformatf("vec%0d", i), d, vt[i].exp);
            end
        end

        // Single 0x55 frame at P=4 with STATUS held on the bus
        bus_write(1, 2'd2, 64'd4);
        bus_write(1, 2'd3, 64'd1);
        bus_write(1, 2'd0, 64'h55);
        set_read(1, 2'd1);
        capture(4, 20, data, bad, busy_n, irq_n, found);
        check("f55_start", 64'(found), 64'd1);
        check("f55_byte", 64'(data), 64'h55);
        check("f55_timing", 64'(bad), 64'd0);
        check("f55_busy_cycles", 64'(busy_n), 64'(NSLOT * 4));
        @(negedge clk);
        #1;
        check("f55_status_after", bus.bus_dout, 64'h2);
        idle_bus();

        // BAUDDIV=0 behaves as one clock per bit
        bus_write(1, 2'd2, 64'd0);
        bus_write(1, 2'd0, 64'hC3);
        frame_check("div0", 8'hC3, 1, 20);
        bus_write(1, 2'd2, 64'd4);

        // FIFO fill, overflow, W1C, drain
        bus_write(1, 2'd3, 64'd0);
        for (int i = 0; i < 17; i++) bus_write(1, 2'd0, 64'(i));
        bus_read(1, 2'd1, d);
        check("ovf_status", d, 64'h1009);
        bus_write(1, 2'd1, 64'h8);
        bus_read(1, 2'd1, d);
        check("ovf_cleared", d, 64'h1001);
        bus_write(1, 2'd3, 64'd1);
        for (int i = 0; i < 16; i++) frame_check($sformatf("drain%0d", i), 8'(i), 4, 100);
        bus_read(1, 2'd1, d);
        check("drain_status", d, 64'h2);

        // Back-to-back frames, no idle gap between them
        bus_write(1, 2'd2, 64'd2);
        bus_write(1, 2'd0, 64'hA5);
        bus_write(1, 2'd0, 64'h3C);
        frame_check("b2b_a5", 8'hA5, 2, 20);
        frame_check("b2b_3c_nogap", 8'h3C, 2, 1);

        // irq behaviour
        bus_write(1, 2'd3, 64'd3);
        bus_write(1, 2'd0, 64'hFF);
        capture(2, 20, data, bad, busy_n, irq_n, found);
        check("irq_frame_byte", 64'(data), 64'hFF);
        check("irq_during_frame", 64'(irq_n), 64'd0);
        @(negedge clk);
        check("irq_idle_first", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_idle_second", 64'(irq), 64'd1);
        bus_write(1, 2'd3, 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("irq_disabled", 64'(irq), 64'd0);

        // Reset mid-DATA with a byte still queued
        bus_write(1, 2'd2, 64'd4);
        bus_write(1, 2'd0, 64'h81);
        bus_write(1, 2'd0, 64'h7E);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_rst_start_seen", 64'(found), 64'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_tx", 64'(uart_tx), 64'd1);
        check("mid_rst_irq", 64'(irq), 64'd0);
        bus_read(1, 2'd1, d);
        check("mid_rst_status", d, 64'h2);
        bus_read(1, 2'd2, d);
        check("mid_rst_baud", d, 64'd868);
        bus_read(1, 2'd3, d);
        check("mid_rst_ctrl", d, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
